// File: rtl/lfsr_lock_checker.sv
// LFSR sequence lock checker: acquires lock on consecutive predicted words,
// flywheels through isolated errors and drops lock after a run of mismatches.
module lfsr_lock_checker #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] POLY       = 8'h8E,
    parameter int unsigned      LOCK_CNT   = 4,
    parameter int unsigned      UNLOCK_CNT = 3,
    parameter int unsigned      ERR_W      = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_soft_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr_err,
    output logic             o_lock,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [7:0]       LOCK_C   = 8'(LOCK_CNT);
    localparam logic [7:0]       UNLOCK_C = 8'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             have_q, have_d;
    logic [7:0]       good_q, good_d;
    logic [7:0]       bad_q, bad_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] exp_w;
    logic             match_w;
    logic [7:0]       good_inc;
    logic [7:0]       bad_inc;

    assign exp_w    = {ref_q[WIDTH-2:0], ^(ref_q & POLY)};
    assign match_w  = (i_data == exp_w);
    assign good_inc = good_q + 8'd1;
    assign bad_inc  = bad_q + 8'd1;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        have_d  = have_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (i_soft_rst) begin
            state_d = UNLOCKED;
            ref_d   = '0;
            have_d  = 1'b0;
            good_d  = '0;
            bad_d   = '0;
            cnt_d   = '0;
        end else begin
            if (i_valid) begin
                unique case (state_q)
                    UNLOCKED: begin
                        ref_d  = i_data;
                        have_d = 1'b1;
                        // All-zero words never count: that is the lock-up state
                        if (have_q && match_w && (i_data != '0)) begin
                            if (good_inc == LOCK_C) begin
                                state_d = LOCKED;
                                good_d  = '0;
                                bad_d   = '0;
                            end else begin
                                good_d = good_inc;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    LOCKED: begin
                        ref_d = exp_w;
                        if (match_w) begin
                            bad_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (cnt_q != ERR_MAX) begin
                                cnt_d = cnt_q + ERR_W'(1);
                            end
                            if (bad_inc == UNLOCK_C) begin
                                state_d = UNLOCKED;
                                have_d  = 1'b0;
                                good_d  = '0;
                                bad_d   = '0;
                            end else begin
                                bad_d = bad_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (i_clr_err) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= UNLOCKED;
            ref_q   <= '0;
            have_q  <= 1'b0;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            have_q  <= have_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_lock    = (state_q == LOCKED);
    assign o_err     = err_q;
    assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_lock_checker.sv
// Scoreboard bench for lfsr_lock_checker: directed scenarios plus random
// traffic checked against a behavioural model.
module tb_lfsr_lock_checker;

    localparam int W  = 8;
    localparam int P  = 'h8E;
    localparam int LC = 4;
    localparam int UC = 3;
    localparam int EW = 16;
    localparam int CMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          srst;
    logic          valid;
    logic          clr;
    logic [W-1:0]  data;
    logic          lock;
    logic          err;
    logic [EW-1:0] cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        int lk;
        int er;
        int ct;
    } exp_t;
    exp_t q[$];

    int m_locked, m_have, m_ref, m_good, m_bad, m_err, m_cnt;

    always #5 clk = ~clk;

    lfsr_lock_checker #(
        .WIDTH(W), .POLY(8'h8E), .LOCK_CNT(LC),
        .UNLOCK_CNT(UC), .ERR_W(EW)
    ) dut (
        .clk(clk),
        .i_rst(rst),
        .i_soft_rst(srst),
        .i_valid(valid),
        .i_data(data),
        .i_clr_err(clr),
        .o_lock(lock),
        .o_err(err),
        .o_err_cnt(cnt)
    );

    function automatic int nxt(input int s);
        int p;
        p = 0;
        for (int i = 0; i < W; i++) begin
            if ((((s & P) >> i) & 1) == 1) p = p ^ 1;
        end
        return ((s << 1) & ((1 << W) - 1)) | p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_ref = 0;
        m_good = 0; m_bad = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model(input int v, input int d, input int c, input int sr);
        int e;
        m_err = 0;
        if (sr != 0) begin
            model_reset();
            return;
        end
        if (v != 0) begin
            e = nxt(m_ref);
            if (m_locked == 0) begin
                if (m_have == 1 && d == e && d != 0) m_good++;
                else m_good = 0;
                m_ref = d;
                m_have = 1;
                if (m_good == LC) begin
                    m_locked = 1; m_good = 0; m_bad = 0;
                end
            end else begin
                m_ref = e;
                if (d == e) begin
                    m_bad = 0;
                end else begin
                    m_bad++;
                    m_err = 1;
                    if (m_cnt < CMAX) m_cnt++;
                    if (m_bad == UC) begin
                        m_locked = 0; m_have = 0; m_good = 0; m_bad = 0;
                    end
                end
            end
        end
        if (c != 0) m_cnt = 0;
    endtask

    task automatic drive(input int v, input int d, input int c, input int sr);
        exp_t x;
        valid = (v != 0);
        data  = W'(d);
        clr   = (c != 0);
        srst  = (sr != 0);
        @(posedge clk);
        model(v, d, c, sr);
        x.lk = m_locked; x.er = m_err; x.ct = m_cnt;
        q.push_back(x);
        #1;
    endtask

    task automatic send(input int d);
        drive(1, d, 0, 0);
    endtask

    task automatic lock_seq();
        send('h01); send('h02); send('h05); send('h0B);
        chk("pre_lock", lock, 0);
        send('h16);
        chk("locked", lock, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_lock", lock, e.lk);
            chk("sb_err", err, e.er);
            chk("sb_cnt", cnt, e.ct);
        end
    end

    initial begin
        int tx, v, d, c, sr;
        rst = 1'b1; srst = 1'b0; valid = 1'b0; clr = 1'b0; data = '0;
        model_reset();
        #12;
        chk("rst_lock", lock, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", cnt, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);

        lock_seq();
        chk("lock_cnt0", cnt, 0);

        send('h2D);
        send('h58);
        chk("single_cnt", cnt, 1);
        chk("single_lock", lock, 1);

        drive(0, 0, 0, 1);
        lock_seq();
        send('hAA); send('hAA);
        chk("loss_hold", lock, 1);
        send('hAA);
        chk("loss_lock", lock, 0);
        chk("loss_cnt", cnt, 3);
        tx = 'h01;
        for (int i = 0; i < 5; i++) begin
            send(tx);
            tx = nxt(tx);
        end
        chk("relock", lock, 1);

        drive(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) send(0);
        chk("zero_lock", lock, 0);

        lock_seq();
        send('h2D);
        chk("pre_clr_cnt", cnt, 1);
        drive(1, 'h33, 1, 0);
        chk("clr_cnt", cnt, 0);
        chk("clr_err", err, 1);
        send('hAA);
        drive(1, 'h00, 0, 1);
        chk("srst_lock", lock, 0);
        chk("srst_cnt", cnt, 0);

        lock_seq();
        send('h2D);
        chk("pre_async_lock", lock, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_lock", lock, 0);
        chk("async_cnt", cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        lock_seq();

        tx = 'h01;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 99) < 85) ? 1 : 0;
            c  = ($urandom_range(0, 199) == 0) ? 1 : 0;
            sr = ($urandom_range(0, 299) == 0) ? 1 : 0;
            if ($urandom_range(0, 499) == 0) tx = $urandom_range(1, 255);
            if (v != 0) begin
                tx = nxt(tx);
                d = tx;
                if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 255);
                if ($urandom_range(0, 63) == 0) d = 0;
            end else begin
                d = $urandom_range(0, 255);
            end
            drive(v, d, c, sr);
        end
        drive(0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
